// File: rtl/linear_collector_pkg.sv
// Shared types and constants for the linear unit result collector.
package linear_collector_pkg;
  localparam int BUF_DEPTH = 96;
  localparam int DW        = 32;
  localparam int ADDR_W    = 7;

  localparam logic [ADDR_W-1:0] SEG_Z_BASE  = 7'h00;
  localparam logic [ADDR_W-1:0] SEG_RH_BASE = 7'h20;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DRAIN
  } coll_state_t;
endpackage

// File: rtl/result_buffer.sv
// Result storage: two same-cycle write ports (even/odd element) and one
// combinational read port. Contents are intentionally not reset.
module result_buffer #(
  parameter int DEPTH = 96,
  parameter int DW    = 32,
  parameter int AW    = 7
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr_e,
  input  logic [AW-1:0] i_waddr_o,
  input  logic [DW-1:0] i_wdata_e,
  input  logic [DW-1:0] i_wdata_o,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);
  localparam logic [AW-1:0] LIM = AW'(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      if (i_waddr_e < LIM) r_mem[i_waddr_e] <= i_wdata_e;
      if (i_waddr_o < LIM) r_mem[i_waddr_o] <= i_wdata_o;
    end
  end

  assign o_rdata = (i_raddr < LIM) ? r_mem[i_raddr] : '0;
endmodule

// File: rtl/linear_result_collector.sv
// Captures even/odd result pairs into the result buffer, then replays the
// segment on a valid/ready stream. COLLECTOR_RELU_EN clamps negative words to 0.
module linear_result_collector #(
  parameter int BUF_DEPTH = 96,
  parameter int DW        = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [6:0]    cfg_base,
  input  logic [5:0]    cfg_pairs,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data1,
  input  logic [DW-1:0] in_data2,
  output logic          m_valid,
  output logic [DW-1:0] m_data,
  output logic          m_last,
  input  logic          m_ready,
  output logic          busy,
  output logic          seg_done,
  output logic          err
);
  import linear_collector_pkg::*;

  localparam logic [7:0] DEPTH_E = 8'(BUF_DEPTH);

  coll_state_t       r_state;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_rd_idx;
  logic [5:0]        r_pairs;
  logic [5:0]        r_pair_cnt;
  logic              r_m_valid;
  logic              r_m_last;
  logic              r_seg_done;
  logic              r_err;

  logic [7:0]        w_cfg_end;
  logic              w_cfg_bad;
  logic [ADDR_W-1:0] w_wa_e;
  logic [ADDR_W-1:0] w_wa_o;
  logic [ADDR_W-1:0] w_ra;
  logic [ADDR_W-1:0] w_last_idx;
  logic              w_we;
  logic              w_hs;
  logic              w_final;
  logic [DW-1:0]     w_wd_e;
  logic [DW-1:0]     w_wd_o;
  logic [DW-1:0]     w_rdata;

  // Range check is one bit wider than the address so a large base cannot wrap.
  assign w_cfg_end  = {1'b0, cfg_base} + {1'b0, cfg_pairs, 1'b0};
  assign w_cfg_bad  = (cfg_pairs == 6'd0) || (w_cfg_end > DEPTH_E);
  assign w_wa_e     = r_base + {r_pair_cnt, 1'b0};
  assign w_wa_o     = w_wa_e + 7'd1;
  assign w_ra       = r_base + r_rd_idx;
  assign w_last_idx = {r_pairs, 1'b0} - 7'd1;
  assign w_we       = (r_state == COLLECT) && in_valid;
  assign w_hs       = r_m_valid && m_ready;
  assign w_final    = w_hs && (r_rd_idx == w_last_idx);

`ifdef COLLECTOR_RELU_EN
  assign w_wd_e = in_data1[DW-1] ? '0 : in_data1;
  assign w_wd_o = in_data2[DW-1] ? '0 : in_data2;
`else
  assign w_wd_e = in_data1;
  assign w_wd_o = in_data2;
`endif

  result_buffer #(
    .DEPTH (BUF_DEPTH),
    .DW    (DW),
    .AW    (ADDR_W)
  ) u_buf (
    .clk       (clk),
    .i_we      (w_we),
    .i_waddr_e (w_wa_e),
    .i_waddr_o (w_wa_o),
    .i_wdata_e (w_wd_e),
    .i_wdata_o (w_wd_o),
    .i_raddr   (w_ra),
    .o_rdata   (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_base     <= '0;
      r_pairs    <= '0;
      r_pair_cnt <= '0;
      r_rd_idx   <= '0;
      r_m_valid  <= 1'b0;
      r_m_last   <= 1'b0;
      r_seg_done <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_seg_done <= 1'b0;
      case (r_state)
        IDLE: begin
          // An accepted start clears err unless a pair arrives alongside it.
          if (start && !w_cfg_bad) begin
            r_state    <= COLLECT;
            r_base     <= cfg_base;
            r_pairs    <= cfg_pairs;
            r_pair_cnt <= '0;
            r_rd_idx   <= '0;
            r_err      <= in_valid;
          end else if (start || in_valid) begin
            r_err <= 1'b1;
          end
        end
        COLLECT: begin
          if (start) r_err <= 1'b1;
          if (in_valid) begin
            r_pair_cnt <= r_pair_cnt + 6'd1;
            if (r_pair_cnt == r_pairs - 6'd1) begin
              r_state   <= DRAIN;
              r_rd_idx  <= '0;
              r_m_valid <= 1'b1;
              r_m_last  <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (start || in_valid) r_err <= 1'b1;
          if (w_hs) begin
            if (w_final) begin
              r_state    <= IDLE;
              r_m_valid  <= 1'b0;
              r_m_last   <= 1'b0;
              r_seg_done <= 1'b1;
            end else begin
              r_rd_idx <= r_rd_idx + 7'd1;
              r_m_last <= (r_rd_idx + 7'd1) == w_last_idx;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign m_valid  = r_m_valid;
  assign m_data   = r_m_valid ? w_rdata : '0;
  assign m_last   = r_m_last;
  assign busy     = (r_state != IDLE);
  assign seg_done = r_seg_done;
  assign err      = r_err;
endmodule

// File: tb/tb_linear_result_collector.sv
// Randomized bench for linear_result_collector with a queue-based reference model.
`timescale 1ns/1ps
module tb_linear_result_collector;
  import linear_collector_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [6:0]  cfg_base = '0;
  logic [5:0]  cfg_pairs = '0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data1 = '0;
  logic [31:0] in_data2 = '0;
  logic        m_ready = 1'b1;
  logic        m_valid, m_last, busy, seg_done, err;
  logic [31:0] m_data;

  always #5 clk = ~clk;

  linear_result_collector #(.BUF_DEPTH(96), .DW(32)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_base(cfg_base), .cfg_pairs(cfg_pairs),
    .in_valid(in_valid), .in_data1(in_data1), .in_data2(in_data2),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
    .busy(busy), .seg_done(seg_done), .err(err)
  );

  int n_chk = 0;
  int n_pass = 0;
  int rmode = 0;
  int sd_cnt = 0;
  bit cmp_en = 1'b0;

  // Reference model: captured words, pending output words, segment/err status.
  logic [31:0] mdl [96];
  logic [31:0] q [$];
  bit          mcol = 1'b0;
  bit          merr = 1'b0;
  bit          exp_sd = 1'b0;
  int          mb, mp, mc;
  logic [31:0] act_log [$];
  bit          last_log [$];

  function automatic logic [31:0] relu(input logic [31:0] d);
`ifdef COLLECTOR_RELU_EN
    return d[31] ? 32'h0 : d;
`else
    return d;
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  always @(posedge clk) begin : model
    bit drn;
    if (rst) begin
      q.delete();
      mcol   = 1'b0;
      merr   = 1'b0;
      exp_sd = 1'b0;
    end else begin
      drn    = (q.size() != 0);
      exp_sd = 1'b0;
      if (drn && m_ready) begin
        void'(q.pop_front());
        exp_sd = (q.size() == 0);
      end
      if (!mcol && !drn) begin
        if (start) begin
          if (cfg_pairs == 0 || int'(cfg_base) + 2 * int'(cfg_pairs) > 96) merr = 1'b1;
          else begin
            mcol = 1'b1; mb = int'(cfg_base); mp = int'(cfg_pairs); mc = 0; merr = in_valid;
          end
        end else if (in_valid) merr = 1'b1;
      end else begin
        if (start || (drn && in_valid)) merr = 1'b1;
        if (mcol && in_valid) begin
          mdl[mb + 2*mc]     = relu(in_data1);
          mdl[mb + 2*mc + 1] = relu(in_data2);
          mc++;
          if (mc == mp) begin
            mcol = 1'b0;
            for (int i = 0; i < 2*mp; i++) q.push_back(mdl[mb + i]);
          end
        end
      end
    end
  end

  always @(negedge clk) begin : compare
    bit ev;
    logic [31:0] ed;
    if (cmp_en) begin
      ev = (q.size() != 0);
      ed = 32'h0;
      if (ev) ed = q[0];
      chk("m_valid", 32'(m_valid), 32'(ev));
      chk("m_data", m_data, ed);
      chk("m_last", 32'(m_last), 32'(ev && q.size() == 1));
      chk("busy", 32'(busy), 32'(mcol || ev));
      chk("seg_done", 32'(seg_done), 32'(exp_sd));
      chk("err", 32'(err), 32'(merr));
      if (m_valid && m_ready) begin
        act_log.push_back(m_data);
        last_log.push_back(m_last);
      end
      if (seg_done) sd_cnt++;
    end
  end

  always @(posedge clk) begin
    #1;
    case (rmode)
      0:       m_ready = 1'b1;
      1:       m_ready = ~m_ready;
      default: m_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_start(input logic [6:0] b, input logic [5:0] p, input bit iv);
    start = 1'b1; cfg_base = b; cfg_pairs = p; in_valid = iv;
    in_data1 = $urandom; in_data2 = $urandom;
    tick();
    start = 1'b0; in_valid = 1'b0;
  endtask

  task automatic send_pair(input logic [31:0] d1, input logic [31:0] d2, input bit st);
    in_valid = 1'b1; in_data1 = d1; in_data2 = d2; start = st;
    tick();
    in_valid = 1'b0; start = 1'b0;
  endtask

  task automatic wait_idle(input bit noise);
    int n;
    n = 0;
    while ((mcol || q.size() != 0) && n < 400) begin
      if (noise && $urandom_range(0, 7) == 0) begin
        in_valid = 1'b1; in_data1 = $urandom;
      end
      tick();
      in_valid = 1'b0;
      n++;
    end
    n_chk++;
    if (n < 400) n_pass++;
    else $display("FAIL wait_idle: timeout after %0d cycles, required drain to finish", n);
    tick();
  endtask

  task automatic check_log(input string nm, input int cnt, input logic [31:0] first);
    int lastpos;
    chk({nm, "_count"}, act_log.size(), cnt);
    lastpos = -1;
    for (int k = 0; k < act_log.size(); k++) begin
      if (k < cnt) chk({nm, "_word"}, act_log[k], first + 32'(k));
      if (last_log[k]) lastpos = k;
    end
    chk({nm, "_lastpos"}, lastpos, cnt - 1);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [6:0] bb;
    logic [5:0] bp;
    int pmax;
    logic [6:0] bad_b [4];
    logic [5:0] bad_p [4];

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    cmp_en = 1'b1;
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(err), 0);
    rst = 1'b0;
    tick();

    // Z segment, ready held high
    act_log.delete(); last_log.delete(); sd_cnt = 0; rmode = 0;
    do_start(SEG_Z_BASE, 6'd16, 1'b0);
    for (int k = 0; k < 16; k++) send_pair(32'(2*k), 32'(2*k+1), 1'b0);
    chk("z_latency_valid", 32'(m_valid), 1);
    chk("z_latency_data", m_data, 0);
    wait_idle(1'b0);
    check_log("z", 32, 32'h0);
    chk("z_seg_done_cnt", sd_cnt, 1);
    chk("z_err", 32'(err), 0);

    // R/H segment, ready toggling; one stray start mid-capture
    act_log.delete(); last_log.delete(); rmode = 1;
    do_start(SEG_RH_BASE, 6'd32, 1'b0);
    for (int k = 0; k < 32; k++) send_pair(32'(32 + 2*k), 32'(33 + 2*k), k == 3);
    wait_idle(1'b0);
    check_log("rh", 64, 32'h20);
    rmode = 0;

    // Stray pair in IDLE, then out-of-range start
    send_pair(32'hDEAD0000, 32'hDEAD0001, 1'b0);
    chk("stray_err", 32'(err), 1);
    do_start(7'h40, 6'd17, 1'b0);
    chk("bad_start_err", 32'(err), 1);
    chk("bad_start_busy", 32'(busy), 0);

    bad_b = '{7'h5F, 7'h10, 7'h7F, 7'h21};
    bad_p = '{6'd1, 6'd0, 6'd48, 6'd38};
    for (int i = 0; i < 4; i++) begin
      do_start(bad_b[i], bad_p[i], 1'b0);
      chk("bad_cfg_busy", 32'(busy), 0);
    end

    // start and pair together in IDLE, then reset mid-capture
    do_start(SEG_Z_BASE, 6'd16, 1'b1);
    chk("start_iv_busy", 32'(busy), 1);
    chk("start_iv_err", 32'(err), 1);
    for (int k = 0; k < 5; k++) send_pair($urandom, $urandom, 1'b0);
    rst = 1'b1;
    tick();
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_m_valid", 32'(m_valid), 0);
    chk("midrst_err", 32'(err), 0);
    chk("midrst_seg_done", 32'(seg_done), 0);
    rst = 1'b0;
    tick();
    act_log.delete(); last_log.delete(); sd_cnt = 0; rmode = 2;
    do_start(SEG_Z_BASE, 6'd16, 1'b0);
    for (int k = 0; k < 16; k++) send_pair(32'(100 + 2*k), 32'(101 + 2*k), 1'b0);
    wait_idle(1'b1);
    check_log("post_rst", 32, 32'd100);
    chk("post_rst_sd", sd_cnt, 1);

    // Sign handling on capture, at the top boundary of the buffer
    act_log.delete(); last_log.delete(); rmode = 0;
    do_start(7'h5E, 6'd1, 1'b0);
    send_pair(32'hBF800000, 32'h3F800000, 1'b0);
    wait_idle(1'b0);
    chk("relu_count", act_log.size(), 2);
    if (act_log.size() == 2) begin
`ifdef COLLECTOR_RELU_EN
      chk("relu_even", act_log[0], 32'h0);
`else
      chk("relu_even", act_log[0], 32'hBF800000);
`endif
      chk("relu_odd", act_log[1], 32'h3F800000);
    end

    // Random segments with gaps, stalls and stray traffic
    rmode = 2;
    for (int it = 0; it < 8; it++) begin
      bb = 7'($urandom_range(0, 94));
      pmax = (96 - int'(bb)) / 2;
      if (pmax > 48) pmax = 48;
      bp = 6'($urandom_range(1, pmax));
      do_start(bb, bp, 1'($urandom_range(0, 3) == 0));
      for (int k = 0; k < int'(bp); k++) begin
        while ($urandom_range(0, 3) == 0) tick();
        send_pair($urandom, $urandom, $urandom_range(0, 9) == 0);
      end
      wait_idle(1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/linear_result_collector.md
# linear_result_collector

Receive side of the 2-lane linear unit output stream (dout1/dout2/done). Each `done` pulse carries one even/odd result pair for a gate segment (x_z at 0x00, 16 pairs; x_r/x_h at 0x20, 32 pairs). The block writes each pair into a 96-word result buffer at its element address. When the segment is complete, it replays that segment in order on a single-word valid/ready stream to the downstream gate nonlinearity stage.

## Interface
- `BUF_DEPTH`, 96: result buffer words.
- `DW`, 32: data width (IEEE-754 single).
- `clk`  in  1  single clock; all logic on posedge.
- `rst`  in  1  reset; **synchronous, active-high**.
- `start`  in  1  one-cycle pulse; latches `cfg_base`/`cfg_pairs`, arms capture.
- `cfg_base`  in  7  segment base element address (0x00 or 0x20).
- `cfg_pairs`  in  6  pairs to capture, 1..48.
- `in_valid`  in  1  pair strobe (linear unit `done`).
- `in_data1`  in  DW  even-element result.
- `in_data2`  in  DW  odd-element result.
- `m_valid`  out  1  output word valid.
- `m_data`  out  DW  output word.
- `m_last`  out  1  final word of segment.
- `m_ready`  in  1  downstream accept.
- `busy`  out  1  state != IDLE.
- `seg_done`  out  1  one-cycle pulse after the last output handshake.
- `err`  out  1  sticky error; cleared only by `rst` or an accepted `start`.

## Operation
- FSM states:
  - IDLE: `start` accepted → COLLECT. `pair_cnt` clears; `cfg_base` and `cfg_pairs` are latched.
  - COLLECT: each `in_valid` writes `in_data1` → buf[base+2·pair_cnt] and `in_data2` → buf[base+2·pair_cnt+1], then `pair_cnt`++. The `in_valid` with `pair_cnt == pairs-1` → DRAIN.
  - DRAIN: `rd_idx` runs from 0 to 2·pairs-1. `m_data` = buf[base+rd_idx]. `rd_idx` advances on `m_valid & m_ready`. The handshake at `rd_idx == 2·pairs-1` → IDLE and pulses `seg_done`.
- Address arithmetic is 7-bit unsigned.
- `start` with `cfg_pairs == 0` or `cfg_base + 2·cfg_pairs > BUF_DEPTH`: rejected, `err` set, state stays IDLE.
- `start` while busy: ignored, `err` set.
- `in_valid` in IDLE or DRAIN: data dropped, buffer untouched, `err` set.
- `start` and `in_valid` in the same IDLE cycle: the start is accepted and the pair is dropped with `err` set.
- Buffer contents persist across segments and are not cleared by reset. The x_z and x_r/x_h regions do not overlap.
- `m_valid`, `m_data`, `m_last` hold stable while `m_valid & !m_ready`.

## Timing
- Reset values: `m_valid`=0, `m_data`=0, `m_last`=0, `busy`=0, `seg_done`=0, `err`=0. State = IDLE, counters = 0.
- `rst` mid-segment: return to IDLE on the next edge. Partial capture is discarded and no `seg_done` pulse is produced.
- Capture accepts one pair per cycle, back-to-back, with no backpressure toward the linear unit.
- Latency: last `in_valid` sampled at edge N → `m_valid`=1 with buf[base] from edge N+1.
- With `m_ready` held high, 2·pairs words stream on consecutive cycles. `seg_done` is high for the cycle after the final handshake.
- `m_data` is driven from the registered buffer through a read mux, with no extra pipeline stage. It is 0 when `m_valid`=0.

## Configuration
- `COLLECTOR_RELU_EN` defined: on capture, any word with bit 31 set (negative, including -0) is stored as 32'h0. All other words are stored unchanged.
- `COLLECTOR_RELU_EN` undefined: words are stored bit-exact.

## Structure
- Package `linear_collector_pkg`:
  - state enum `coll_state_t` (IDLE, COLLECT, DRAIN)
  - `BUF_DEPTH`
  - `ADDR_W` = 7
  - segment base constants `SEG_Z_BASE` = 7'h00 and `SEG_RH_BASE` = 7'h20
- Sub-module `result_buffer`: BUF_DEPTH×DW register array with two synchronous write ports (even/odd, same cycle) and one combinational read port. The top level holds the FSM, counters and handshake logic.

## Test plan
- Z segment: `start` with base 0x00, pairs 16; 16 back-to-back pairs with `in_data1`=2k, `in_data2`=2k+1 → 32 words 0..31 in order, `m_last` on word 31, `seg_done` one cycle later, `err`=0.
- R/H segment: base 0x20, pairs 32; `m_ready` toggling 1,0,1,0 → 64 words 0x20..0x5F in order, data held during stalls, no loss or duplication.
- Stray `in_valid` in IDLE, then `start` with base 0x40, pairs 17 (0x40+34 > 96) → `err`=1, `busy`=0, buffer unchanged.
- `rst` asserted after 5 of 16 pairs → all outputs at reset values next cycle; a new full segment then completes normally.
- `COLLECTOR_RELU_EN`: capture a pair (32'hBF800000, 32'h3F800000) → outputs 32'h0, 32'h3F800000. Without the macro → outputs 32'hBF800000, 32'h3F800000.
